fp32_mul_round_pack: RTL and testbench
======================================

Name: fp32_mul_round_pack

Overview:
Back end of the single-precision IEEE754 multiplier. Consumes the 48-bit mantissa product from the 24x24 array multiplier, together with the two original operands. Performs exponent add, normalisation, round-to-nearest-even, special-case resolution and packing. Two-stage registered pipeline with valid/ready handshake on both sides.

Parameters:
BIAS, 127, exponent bias subtracted from the exponent sum.
QNAN, 32'h7FC00000, canonical NaN emitted for every NaN result.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/product beat valid
in_ready  output  1  block can accept a beat this cycle
op_a  input  32  operand A, IEEE754 single
op_b  input  32  operand B, IEEE754 single
prod  input  48  product of mantissas {exp!=0, frac}, from the 24x24 multiplier, same cycle as op_a/op_b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  32  packed IEEE754 result
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: asynchronous on rst_n low, regardless of clk. All pipeline valids, out_valid, out_data and out_flags clear to 0. in_ready is 0 while rst_n is low, then 1 from the first cycle after release.
- Handshake: a beat transfers when valid&ready are both high at a rising edge. Inputs may change freely when in_valid=0.
  - Stage 2 advances when !s2_valid | out_ready. Stage 1 advances when !s1_valid | stage-2 advance. in_ready equals the stage-1 advance condition (combinational from out_ready allowed).
  - With out_ready held high, latency is 2 cycles and throughput is 1 beat/cycle.
  - out_data/out_flags are held stable while out_valid=1 and out_ready=0.
  - No loss, no duplication, order preserved.
- Stage 1 (registered):
  - sign = a[31]^b[31].
  - e = a_exp + b_exp - BIAS, 10-bit signed.
  - If prod[47]=1: m = prod[46:24], g = prod[23], st = |prod[22:0], e = e+1.
  - Else: m = prod[45:23], g = prod[22], st = |prod[21:0].
  - Classify operands. exp=0 means zero (denormals are flushed to zero and prod is ignored). exp=255 with frac=0 is Inf. exp=255 with frac!=0 is NaN; sNaN when frac[22]=0.
- Stage 2 (registered to outputs):
  - Rounding: round_up = g & (st | m[0]). The 24-bit value {1,m}+round_up may carry out; on carry, m=0 and e=e+1.
  - inexact = g|st (finite normal path).
  - e >= 255: result {sign,8'hFF,0}, overflow=1, inexact=1.
  - e <= 0: result {sign,31'b0}, underflow=1, inexact=1. Tininess is detected after rounding.
  - Otherwise: {sign, e[7:0], m}.
- Special-case priority (overrides the arithmetic path; overflow/underflow/inexact forced to 0):
  1. Any NaN operand, or Inf*zero: QNAN. invalid=1 only for Inf*zero or an sNaN operand.
  2. Any Inf operand: {sign,8'hFF,23'b0}.
  3. Any zero operand: {sign,31'b0}.
- Simultaneous events: a new input is accepted in the same cycle an output is consumed (full pipe stays full). A reset asserted mid-operation discards all in-flight beats and produces no output on release.

Test Plan:
- 1.5*2.0: op_a=0x3FC00000, op_b=0x40000000, prod=0x600000000000, out_ready=1 -> out_data=0x40400000, flags=0000, out_valid exactly 2 cycles after acceptance.
- Tie rounding: op_a=0x3F800001, op_b=0x3FC00000, prod=0x600000C00000 -> m=0xC00001, g=1, st=0, rounds up -> out_data=0x3FC00002, flags=0001.
- Range limits: 0x7F000000*0x7F000000 -> 0x7F800000, flags=0101. Then 0x00800000*0x00800000 (prod=0x400000000000) -> 0x00000000, flags=0011.
- Specials: 0x7F800000*0x00000000 -> 0x7FC00000, flags=1000. Then 0xFF800000*0x40000000 -> 0xFF800000, flags=0000. Then 0x7F800001*0x3F800000 -> 0x7FC00000, flags=1000.
- Backpressure: feed 4 back-to-back beats (1.0*k, k=1..4) with out_ready=0 -> in_ready drops after 2 accepted and out_data is held. Release out_ready -> 0x3F800000, 0x40000000, 0x40400000, 0x40800000 in order, each exactly once.
- Reset mid-flight: both stages valid, pull rst_n low between clock edges -> out_valid=0 and out_data=0 immediately. After release, no stale result appears and the next beat completes with 2-cycle latency.

Source files
------------

// File: rtl/fp32_mul_round_pack_if.sv
// Operand/product beat in, packed IEEE754 result out; both sides use valid/ready.
// The slave modport is the multiplier back end, the master modport is its environment.
interface fp32_mul_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [47:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, op_a, op_b, prod, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, op_a, op_b, prod, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp32_mul_round_pack.sv
// FP32 multiplier back end: exponent add, normalise, round-to-nearest-even, specials, pack.
// Stage 1 registers the normalised fields and operand class, stage 2 registers the packed result.
module fp32_mul_round_pack #(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input logic                    clk,
  input logic                    rst_n,
  fp32_mul_round_pack_if.slave   bus
);

  // ---------------- handshake ----------------
  logic ready_en_reg;
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv  = !out_valid_reg || bus.out_ready;
  assign s1_adv  = !s1_valid_reg || s2_adv;
  assign bus.in_ready = ready_en_reg && s1_adv;
  assign in_fire = bus.in_valid && bus.in_ready;

  // in_ready stays low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_reg <= 1'b0;
    else        ready_en_reg <= 1'b1;
  end

  // ---------------- operand classification ----------------
  logic [31:0] opnd [2];
  logic [1:0]  is_zero;
  logic [1:0]  is_inf;
  logic [1:0]  is_nan;
  logic [1:0]  is_snan;

  assign opnd[0] = bus.op_a;
  assign opnd[1] = bus.op_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      assign is_zero[gi] = (opnd[gi][30:23] == 8'h00);
      assign is_inf[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'd0);
      assign is_nan[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'd0);
      assign is_snan[gi] = is_nan[gi] && !opnd[gi][22];
    end
  endgenerate

  logic inf_times_zero;
  assign inf_times_zero = (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);

  // ---------------- stage 1 datapath ----------------
  logic [9:0]  exp_sum;
  logic [9:0]  exp_next;
  logic [22:0] m_next;
  logic        g_next;
  logic        st_next;

  // 10-bit wrap-around arithmetic; the result is interpreted as two's complement
  assign exp_sum = 10'({2'b00, bus.op_a[30:23]}) + 10'({2'b00, bus.op_b[30:23]}) - 10'(BIAS);

  always_comb begin
    exp_next = exp_sum;
    m_next   = bus.prod[45:23];
    g_next   = bus.prod[22];
    st_next  = |bus.prod[21:0];
    if (bus.prod[47]) begin
      exp_next = exp_sum + 10'd1;
      m_next   = bus.prod[46:24];
      g_next   = bus.prod[23];
      st_next  = |bus.prod[22:0];
    end
  end

  logic              s1_sign_reg;
  logic signed [9:0] s1_exp_reg;
  logic [22:0]       s1_m_reg;
  logic              s1_g_reg;
  logic              s1_st_reg;
  logic              s1_nan_reg;
  logic              s1_invalid_reg;
  logic              s1_inf_reg;
  logic              s1_zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_exp_reg     <= '0;
      s1_m_reg       <= '0;
      s1_g_reg       <= 1'b0;
      s1_st_reg      <= 1'b0;
      s1_nan_reg     <= 1'b0;
      s1_invalid_reg <= 1'b0;
      s1_inf_reg     <= 1'b0;
      s1_zero_reg    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_fire;
      if (in_fire) begin
        s1_sign_reg    <= bus.op_a[31] ^ bus.op_b[31];
        s1_exp_reg     <= $signed(exp_next);
        s1_m_reg       <= m_next;
        s1_g_reg       <= g_next;
        s1_st_reg      <= st_next;
        s1_nan_reg     <= (|is_nan) || inf_times_zero;
        s1_invalid_reg <= (|is_snan) || inf_times_zero;
        s1_inf_reg     <= |is_inf;
        s1_zero_reg    <= |is_zero;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic              round_up;
  logic [24:0]       mant_sum;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_m;
  logic [31:0]       data_next;
  logic [3:0]        flags_next;

  assign round_up = s1_g_reg && (s1_st_reg || s1_m_reg[0]);
  assign mant_sum = {2'b01, s1_m_reg} + 25'(round_up);
  assign rnd_exp  = mant_sum[24] ? (s1_exp_reg + 10'sd1) : s1_exp_reg;
  assign rnd_m    = mant_sum[24] ? 23'd0 : mant_sum[22:0];

  always_comb begin
    data_next  = {s1_sign_reg, rnd_exp[7:0], rnd_m};
    flags_next = {3'b000, s1_g_reg || s1_st_reg};
    if (s1_nan_reg) begin
      data_next  = QNAN;
      flags_next = {s1_invalid_reg, 3'b000};
    end else if (s1_inf_reg) begin
      data_next  = {s1_sign_reg, 8'hFF, 23'd0};
      flags_next = 4'b0000;
    end else if (s1_zero_reg) begin
      data_next  = {s1_sign_reg, 31'd0};
      flags_next = 4'b0000;
    end else if (rnd_exp >= 10'sd255) begin
      data_next  = {s1_sign_reg, 8'hFF, 23'd0};
      flags_next = 4'b0101;
    end else if (rnd_exp <= 10'sd0) begin
      // tininess is judged on the rounded exponent
      data_next  = {s1_sign_reg, 31'd0};
      flags_next = 4'b0011;
    end
  end

  logic [31:0] out_data_reg;
  logic [3:0]  out_flags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_flags_reg <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg  <= data_next;
        out_flags_reg <= flags_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_flags = out_flags_reg;

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Directed bench for fp32_mul_round_pack: vector table, backpressure ordering and mid-flight reset.
module tb_fp32_mul_round_pack;

  logic clk;
  logic rst_n;

  fp32_mul_round_pack_if bus ();

  fp32_mul_round_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] p;
    logic [31:0] d;
    logic [3:0]  f;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", nm, act);
    end
  endtask

  // One beat with out_ready high; checks 2-cycle latency, data and flags.
  task automatic do_vec(input vec_t v);
    int n;
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op_a      = v.a;
    bus.op_b      = v.b;
    bus.prod      = v.p;
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check({v.name, " accept timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd2);
    check({v.name, " data"}, bus.out_data, v.d);
    check({v.name, " flags"}, 32'(bus.out_flags), 32'(v.f));
  endtask

  logic [31:0] bp_b   [4];
  logic [47:0] bp_p   [4];
  logic [31:0] bp_exp [4];
  logic [31:0] rx     [8];

  initial begin
    int idx;
    int nrx;
    int seen;
    logic acc_in;
    logic acc_out;
    logic [31:0] od;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 48'h600000000000, 32'h40400000, 4'b0000, "1.5*2.0"};
    vecs[1]  = '{32'h3F800001, 32'h3FC00000, 48'h600000C00000, 32'h3FC00002, 4'b0001, "tie round up"};
    vecs[2]  = '{32'h7F000000, 32'h7F000000, 48'h400000000000, 32'h7F800000, 4'b0101, "overflow"};
    vecs[3]  = '{32'h00800000, 32'h00800000, 48'h400000000000, 32'h00000000, 4'b0011, "underflow"};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 48'h000000000000, 32'h7FC00000, 4'b1000, "inf*zero"};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 48'h000000000000, 32'hFF800000, 4'b0000, "-inf*2"};
    vecs[6]  = '{32'h7F800001, 32'h3F800000, 48'h000000000000, 32'h7FC00000, 4'b1000, "snan*1"};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 48'h000000000000, 32'h7FC00000, 4'b0000, "qnan*1"};
    vecs[8]  = '{32'h00000000, 32'hC0400000, 48'h000000000000, 32'h80000000, 4'b0000, "0*-3"};
    vecs[9]  = '{32'h40400000, 32'h40400000, 48'h900000000000, 32'h41100000, 4'b0000, "3*3"};
    vecs[10] = '{32'h3FC00000, 32'hC0000000, 48'h600000000000, 32'hC0400000, 4'b0000, "1.5*-2"};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 48'h7FFFFFFFFFFF, 32'h40000000, 4'b0001, "round carry"};

    bp_b[0] = 32'h3F800000; bp_p[0] = 48'h400000000000; bp_exp[0] = 32'h3F800000;
    bp_b[1] = 32'h40000000; bp_p[1] = 48'h400000000000; bp_exp[1] = 32'h40000000;
    bp_b[2] = 32'h40400000; bp_p[2] = 48'h600000000000; bp_exp[2] = 32'h40400000;
    bp_b[3] = 32'h40800000; bp_p[3] = 48'h400000000000; bp_exp[3] = 32'h40800000;

    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.prod      = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #6;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", bus.out_data, 32'd0);
    check("reset out_flags", 32'(bus.out_flags), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after release", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) do_vec(vecs[i]);

    // Backpressure: out_ready low for 5 cycles, then drain.
    idx = 0;
    nrx = 0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = (c >= 5);
      if (idx < 4) begin
        bus.in_valid = 1'b1;
        bus.op_a     = 32'h3F800000;
        bus.op_b     = bp_b[idx];
        bus.prod     = bp_p[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("bp data held c2", bus.out_data, 32'h3F800000);
      if (c == 4) begin
        check("bp accepted before release", 32'(idx), 32'd2);
        check("bp in_ready stalled", 32'(bus.in_ready), 32'd0);
        check("bp out_valid held", 32'(bus.out_valid), 32'd1);
        check("bp data held c4", bus.out_data, 32'h3F800000);
      end
      acc_in  = bus.in_valid && bus.in_ready;
      acc_out = bus.out_valid && bus.out_ready;
      od      = bus.out_data;
      @(posedge clk);
      if (acc_in) idx++;
      if (acc_out) begin
        if (nrx < 8) rx[nrx] = od;
        nrx++;
      end
      @(negedge clk);
    end
    check("bp beats accepted", 32'(idx), 32'd4);
    check("bp results count", 32'(nrx), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("bp result %0d", k), rx[k], bp_exp[k]);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h3F800000;
      bus.op_b     = bp_b[k + 2];
      bus.prod     = bp_p[k + 2];
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("pipe full before reset", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset out_data", bus.out_data, 32'd0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no stale output", 32'(seen), 32'd0);
    do_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
